branch_sequencer: RTL and testbench



---
 rtl/branch_sequencer.sv | 142 ++++++++++++++
 tb/tb_branch_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/branch_sequencer.sv
// Program-counter sequencer that drives fetch and resolves branches from the registered branch unit.
// Latency: all outputs are registered. A taken redirect flushes for FLUSH_CYCLES cycles before the target is fetched.
// Backpressure: stall_in freezes PC advance in RUN and parks a resolved decision in HOLD; it never extends flush.
// Optional build macro BRANCH_SEQ_PERF_EN adds the saturating ctrl_count and taken_count outputs.
module branch_sequencer #(
    parameter int ADDR_W       = 10,
    parameter int FLUSH_CYCLES = 2,
    parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_in,
    input  logic              is_ctrl,
    input  logic              branch,
    input  logic [ADDR_W-1:0] target_addr,
    output logic [ADDR_W-1:0] pc,
    output logic              pc_valid,
    output logic              flush,
    output logic              busy
`ifdef BRANCH_SEQ_PERF_EN
    ,
    output logic [15:0]       ctrl_count,
    output logic [15:0]       taken_count
`endif
);

    typedef enum logic [1:0] {RUN, RESOLVE, HOLD, FLUSH} state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] pc_d;
    logic              pc_valid_d, flush_d;
    logic [3:0]        cnt, cnt_d;
    logic              taken_q, taken_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic              apply;
    logic              dec_taken;
    logic [ADDR_W-1:0] dec_tgt;

    // Next-state and next-output logic; apply merges the RESOLVE and HOLD decision paths.
    always_comb begin
        state_d    = state;
        pc_d       = pc;
        pc_valid_d = pc_valid;
        flush_d    = flush;
        cnt_d      = cnt;
        taken_d    = taken_q;
        tgt_d      = tgt_q;
        apply      = 1'b0;
        dec_taken  = taken_q;
        dec_tgt    = tgt_q;
        case (state)
            RUN: begin
                if (!stall_in) begin
                    if (is_ctrl) begin
                        pc_valid_d = 1'b0;
                        state_d    = RESOLVE;
                    end else begin
                        pc_d       = pc + ADDR_W'(1);
                        pc_valid_d = 1'b1;
                    end
                end
            end
            RESOLVE: begin
                // The branch unit result is only valid now, so it is always captured.
                taken_d   = branch;
                tgt_d     = target_addr;
                dec_taken = branch;
                dec_tgt   = target_addr;
                if (stall_in) begin
                    state_d = HOLD;
                end else begin
                    apply = 1'b1;
                end
            end
            HOLD: begin
                if (!stall_in) begin
                    apply = 1'b1;
                end
            end
            FLUSH: begin
                if (cnt != 4'd0) begin
                    cnt_d = cnt - 4'd1;
                end else begin
                    flush_d    = 1'b0;
                    pc_valid_d = 1'b1;
                    state_d    = RUN;
                end
            end
            default: state_d = RUN;
        endcase
        if (apply) begin
            if (dec_taken) begin
                pc_d       = dec_tgt;
                pc_valid_d = 1'b0;
                flush_d    = 1'b1;
                cnt_d      = 4'(FLUSH_CYCLES - 1);
                state_d    = FLUSH;
            end else begin
                pc_d       = pc + ADDR_W'(1);
                pc_valid_d = 1'b1;
                state_d    = RUN;
            end
        end
    end

    // State, capture and output registers; busy is registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            pc       <= PC_RESET;
            pc_valid <= 1'b1;
            flush    <= 1'b0;
            busy     <= 1'b0;
            cnt      <= 4'd0;
            taken_q  <= 1'b0;
            tgt_q    <= '0;
        end else begin
            state    <= state_d;
            pc       <= pc_d;
            pc_valid <= pc_valid_d;
            flush    <= flush_d;
            busy     <= (state_d != RUN);
            cnt      <= cnt_d;
            taken_q  <= taken_d;
            tgt_q    <= tgt_d;
        end
    end

`ifdef BRANCH_SEQ_PERF_EN
    // Saturating counters of applied decisions and applied taken decisions.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_count  <= 16'd0;
            taken_count <= 16'd0;
        end else if (apply) begin
            if (ctrl_count != 16'hFFFF) ctrl_count <= ctrl_count + 16'd1;
            if (dec_taken && taken_count != 16'hFFFF) taken_count <= taken_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
module tb_branch_sequencer;
    localparam int AW = 10;
    localparam int FC = 2;

    logic          clk = 1'b0;
    logic          rst, stall_in, is_ctrl, branch;
    logic [AW-1:0] target_addr;
    logic [AW-1:0] pc;
    logic          pc_valid, flush, busy;
`ifdef BRANCH_SEQ_PERF_EN
    logic [15:0]   ctrl_count, taken_count;
`endif

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    branch_sequencer #(.ADDR_W(AW), .FLUSH_CYCLES(FC), .PC_RESET('0)) dut (
        .clk(clk), .rst(rst), .stall_in(stall_in), .is_ctrl(is_ctrl),
        .branch(branch), .target_addr(target_addr),
        .pc(pc), .pc_valid(pc_valid), .flush(flush), .busy(busy)
`ifdef BRANCH_SEQ_PERF_EN
        , .ctrl_count(ctrl_count), .taken_count(taken_count)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural model: a control op in flight is "resolving" for its one
    // cycle, "waiting" while stalled afterwards, then flush runs for a number
    // of remaining cycles.
    logic [AW-1:0] m_pc;
    logic          m_valid, m_flush, m_busy;
    bit            m_resolving, m_waiting, m_dtaken;
    logic [AW-1:0] m_dtgt;
    int            m_flush_left;
    int            m_ctrl, m_taken;

    always @(posedge clk) begin
        if (rst) begin
            m_pc = '0; m_valid = 1; m_flush = 0; m_busy = 0;
            m_resolving = 0; m_waiting = 0; m_dtaken = 0; m_dtgt = '0;
            m_flush_left = 0; m_ctrl = 0; m_taken = 0;
        end else if (m_flush_left > 0) begin
            m_flush_left--;
            if (m_flush_left == 0) begin
                m_flush = 0; m_valid = 1; m_busy = 0;
            end
        end else if (m_resolving || m_waiting) begin
            if (m_resolving) begin
                m_dtaken = branch;
                m_dtgt   = target_addr;
            end
            m_resolving = 0;
            if (stall_in) begin
                m_waiting = 1;
            end else begin
                m_waiting = 0;
                if (m_ctrl < 65535) m_ctrl++;
                if (m_dtaken) begin
                    if (m_taken < 65535) m_taken++;
                    m_pc = m_dtgt; m_flush = 1; m_flush_left = FC;
                end else begin
                    m_pc = m_pc + 1'b1; m_valid = 1; m_busy = 0;
                end
            end
        end else if (!stall_in) begin
            if (is_ctrl) begin
                m_resolving = 1; m_valid = 0; m_busy = 1;
            end else begin
                m_pc = m_pc + 1'b1;
            end
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            cmp("model_pc", 32'(pc), 32'(m_pc));
            cmp("model_pc_valid", 32'(pc_valid), 32'(m_valid));
            cmp("model_flush", 32'(flush), 32'(m_flush));
            cmp("model_busy", 32'(busy), 32'(m_busy));
`ifdef BRANCH_SEQ_PERF_EN
            cmp("model_ctrl_count", 32'(ctrl_count), 32'(m_ctrl));
            cmp("model_taken_count", 32'(taken_count), 32'(m_taken));
`endif
        end
    end

    task automatic cyc(input logic r, input logic s, input logic c, input logic b, input logic [AW-1:0] t);
        rst = r; stall_in = s; is_ctrl = c; branch = b; target_addr = t;
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [AW-1:0] epc, input logic ev,
                       input logic ef, input logic eb);
        cmp({name, "_pc"}, 32'(pc), 32'(epc));
        cmp({name, "_valid"}, 32'(pc_valid), 32'(ev));
        cmp({name, "_flush"}, 32'(flush), 32'(ef));
        cmp({name, "_busy"}, 32'(busy), 32'(eb));
    endtask

    initial begin
        rst = 1; stall_in = 0; is_ctrl = 0; branch = 0; target_addr = '0;
        cyc(1, 0, 0, 0, '0);
        started = 1'b1;
        cyc(1, 0, 0, 0, '0);
        lit("reset", 10'h000, 1, 0, 0);

        // Free run: pc 1..5
        for (int i = 1; i <= 5; i++) begin
            cyc(0, 0, 0, 0, '0);
            lit("freerun", AW'(i), 1, 0, 0);
        end

        // Taken branch to 0x040
        cyc(0, 0, 1, 0, '0);          lit("t_resolve", 10'h005, 0, 0, 1);
        cyc(0, 0, 0, 1, 10'h040);     lit("t_flush1", 10'h040, 0, 1, 1);
        cyc(0, 0, 1, 0, '0);          lit("t_flush2", 10'h040, 0, 1, 1);
        cyc(0, 0, 0, 0, '0);          lit("t_fetch", 10'h040, 1, 0, 0);
        cyc(0, 0, 0, 0, '0);          lit("t_next", 10'h041, 1, 0, 0);

        // Not-taken branch
        cyc(0, 0, 1, 0, '0);          lit("nt_resolve", 10'h041, 0, 0, 1);
        cyc(0, 0, 0, 0, 10'h200);     lit("nt_fall", 10'h042, 1, 0, 0);

        // Stall in RUN holds pc and ignores is_ctrl
        cyc(0, 1, 1, 0, '0);          lit("run_stall", 10'h042, 1, 0, 0);

        // Taken branch to 0x123 stalled in RESOLVE plus three HOLD cycles
        cyc(0, 0, 1, 0, '0);          lit("h_resolve", 10'h042, 0, 0, 1);
        cyc(0, 1, 0, 1, 10'h123);     lit("h_hold0", 10'h042, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0, 10'h3FF);  lit("h_hold", 10'h042, 0, 0, 1);
        end
        cyc(0, 0, 0, 0, 10'h3FF);     lit("h_apply", 10'h123, 0, 1, 1);
        cyc(0, 1, 0, 0, '0);          lit("h_flush2", 10'h123, 0, 1, 1);
        cyc(0, 1, 0, 0, '0);          lit("h_fetch", 10'h123, 1, 0, 0);

        // Self-loop: target equals current pc
        cyc(0, 0, 1, 0, '0);
        cyc(0, 0, 0, 1, 10'h123);     lit("self_flush", 10'h123, 0, 1, 1);
        cyc(0, 0, 0, 0, '0);
        cyc(0, 0, 0, 0, '0);          lit("self_fetch", 10'h123, 1, 0, 0);

        // Wrap 0x3FF -> 0
        cyc(0, 0, 1, 0, '0);
        cyc(0, 0, 0, 1, 10'h3FE);
        cyc(0, 0, 0, 0, '0);
        cyc(0, 0, 0, 0, '0);          lit("w_fetch", 10'h3FE, 1, 0, 0);
        cyc(0, 0, 0, 0, '0);          lit("w_3ff", 10'h3FF, 1, 0, 0);
        cyc(0, 0, 0, 0, '0);          lit("w_wrap", 10'h000, 1, 0, 0);

        // Reset during FLUSH with one flush cycle still to go
        cyc(0, 0, 1, 0, '0);
        cyc(0, 0, 0, 1, 10'h200);     lit("r_flush", 10'h200, 0, 1, 1);
        cyc(1, 0, 0, 0, '0);          lit("r_reset", 10'h000, 1, 0, 0);
        cyc(0, 0, 0, 0, '0);          lit("r_after", 10'h001, 1, 0, 0);

`ifdef BRANCH_SEQ_PERF_EN
        // Two taken, one not taken after the reset above
        cyc(0, 0, 1, 0, '0); cyc(0, 0, 0, 1, 10'h010); cyc(0, 0, 0, 0, '0); cyc(0, 0, 0, 0, '0);
        cyc(0, 0, 1, 0, '0); cyc(0, 0, 0, 0, '0);
        cyc(0, 0, 1, 0, '0); cyc(0, 1, 0, 1, 10'h020); cyc(0, 0, 0, 0, '0);
        cmp("perf_ctrl", 32'(ctrl_count), 32'd3);
        cmp("perf_taken", 32'(taken_count), 32'd2);
`endif

        // Pseudo-random mix checked against the model every cycle
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 4) == 0), $urandom_range(0, 1) == 1,
                AW'($urandom_range(0, 1023)));
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
